// File: rtl/uart_reg_responder.sv
`timescale 1ns/1ps
// Byte-protocol register responder behind a UART: parses write/read frames, updates
// an 8-bit register file and answers with one byte. Define UART_RESP_CHECKSUM_EN for XOR-checked frames.
module uart_reg_responder #(
  parameter int NREGS       = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_done,
  input  logic [7:0]           rx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  output logic [8*NREGS-1:0]   regs_out,
  output logic                 busy,
  output logic                 err
);

  localparam int             CW      = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [8:0]     NREGS9  = 9'(NREGS);
  localparam logic [7:0]     CMD_WR  = 8'h57;
  localparam logic [7:0]     CMD_RD  = 8'h52;
  localparam logic [7:0]     RSP_ACK = 8'h06;
  localparam logic [7:0]     RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
`ifdef UART_RESP_CHECKSUM_EN
    S_GET_CSUM,
`endif
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t        r_state, w_next;
  logic          r_is_write, r_bad_cmd;
  logic [7:0]    r_addr, r_data, r_tx_data;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_regs [NREGS];
  logic          w_in_get, w_timeout, w_addr_ok, w_csum_ok, w_nak, w_wr_en;
  logic [7:0]    w_rd_val;
`ifdef UART_RESP_CHECKSUM_EN
  logic [7:0]    r_csum;
  logic          r_csum_ok;
  assign w_csum_ok = r_csum_ok;
`else
  assign w_csum_ok = 1'b1;
`endif

`ifdef UART_RESP_CHECKSUM_EN
  assign w_in_get = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA) || (r_state == S_GET_CSUM);
`else
  assign w_in_get = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
`endif
  // A byte landing on the expiry cycle keeps the frame alive.
  assign w_timeout = w_in_get && (r_cnt == TO_LAST) && !rx_done;
  assign w_addr_ok = {1'b0, r_addr} < NREGS9;
  assign w_nak     = r_bad_cmd || !w_addr_ok || !w_csum_ok;
  assign w_wr_en   = (r_state == S_EXEC) && r_is_write && !w_nak;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: assigning w_next before the case keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (rx_done) w_next = (rx_data == CMD_WR || rx_data == CMD_RD) ? S_GET_ADDR : S_EXEC;
      S_GET_ADDR:
        if (rx_done) begin
`ifdef UART_RESP_CHECKSUM_EN
          w_next = r_is_write ? S_GET_DATA : S_GET_CSUM;
`else
          w_next = r_is_write ? S_GET_DATA : S_EXEC;
`endif
        end else if (w_timeout) w_next = S_IDLE;
      S_GET_DATA:
        if (rx_done) begin
`ifdef UART_RESP_CHECKSUM_EN
          w_next = S_GET_CSUM;
`else
          w_next = S_EXEC;
`endif
        end else if (w_timeout) w_next = S_IDLE;
`ifdef UART_RESP_CHECKSUM_EN
      S_GET_CSUM:
        if (rx_done)        w_next = S_EXEC;
        else if (w_timeout) w_next = S_IDLE;
`endif
      S_EXEC:    w_next = S_SEND;
      S_SEND:    if (!tx_busy) w_next = S_WAIT_TX;
      S_WAIT_TX: if (tx_done)  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset drops them at once.
  assign tx_en   = (r_state == S_SEND) && !tx_busy;
  assign busy    = (r_state != S_IDLE);
  assign err     = ((r_state == S_EXEC) && w_nak) || w_timeout;
  assign tx_data = r_tx_data;

  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NREGS; k++)
      if (r_addr == 8'(k)) w_rd_val = r_regs[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_write <= 1'b0;
      r_bad_cmd  <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_tx_data  <= '0;
      r_cnt      <= '0;
`ifdef UART_RESP_CHECKSUM_EN
      r_csum     <= '0;
      r_csum_ok  <= 1'b0;
`endif
    end else begin
      if (w_in_get && !rx_done && !w_timeout) r_cnt <= r_cnt + 1'b1;
      else                                   r_cnt <= '0;
      case (r_state)
        S_IDLE:
          if (rx_done) begin
            r_is_write <= (rx_data == CMD_WR);
            r_bad_cmd  <= !(rx_data == CMD_WR || rx_data == CMD_RD);
`ifdef UART_RESP_CHECKSUM_EN
            r_csum     <= rx_data;
`endif
          end
        S_GET_ADDR:
          if (rx_done) begin
            r_addr <= rx_data;
`ifdef UART_RESP_CHECKSUM_EN
            r_csum <= r_csum ^ rx_data;
`endif
          end
        S_GET_DATA:
          if (rx_done) begin
            r_data <= rx_data;
`ifdef UART_RESP_CHECKSUM_EN
            r_csum <= r_csum ^ rx_data;
`endif
          end
`ifdef UART_RESP_CHECKSUM_EN
        S_GET_CSUM:
          if (rx_done) r_csum_ok <= (rx_data == r_csum);
`endif
        S_EXEC:
          r_tx_data <= w_nak ? RSP_NAK : (r_is_write ? RSP_ACK : w_rd_val);
        default: ;
      endcase
    end
  end

  // NOTE: the register file is reset because the host may read any entry before writing it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++)
        if (w_wr_en && r_addr == 8'(k)) r_regs[k] <= r_data;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int k = 0; k < NREGS; k++) regs_out[8*k +: 8] = r_regs[k];
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
`timescale 1ns/1ps
// Self-checking bench for uart_reg_responder: directed vector table, multi-cycle corner
// sequences and random frames scored against an array-based register model.
module tb_uart_reg_responder;

  localparam int NREGS = 16;
  localparam int TO    = 64;

  logic               clk = 1'b0;
  logic               rst, rx_done, tx_busy, tx_done;
  logic [7:0]         rx_data;
  logic               tx_en, busy, err;
  logic [7:0]         tx_data;
  logic [8*NREGS-1:0] regs_out;

  uart_reg_responder #(.NREGS(NREGS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_en(tx_en), .tx_data(tx_data),
    .regs_out(regs_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         err_cnt = 0, txen_cnt = 0, txen_cyc = 0, last_rx_cyc = 0;
  logic [7:0] txq [$];
  int         n_checks = 0, n_pass = 0;
  logic [7:0] model [NREGS];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (err) err_cnt <= err_cnt + 1;
    if (tx_en) begin
      txen_cnt <= txen_cnt + 1;
      txen_cyc <= cyc;
      txq.push_back(tx_data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f = '0;
    for (int k = 0; k < NREGS; k++) f[8*k +: 8] = model[k];
    return f;
  endfunction

  // Spec rules: legal write stores and ACKs, legal read returns the value, all else NAKs.
  function automatic void model_exec(input logic [7:0] b0, b1, b2,
                                     output logic [7:0] resp, output logic nak);
    nak = 1'b0;
    if (b0 == 8'h57 && int'(b1) < NREGS) begin
      model[b1] = b2;
      resp = 8'h06;
    end else if (b0 == 8'h52 && int'(b1) < NREGS) begin
      resp = model[b1];
    end else begin
      resp = 8'h15;
      nak  = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_data     = b;
    rx_done     = 1'b1;
    last_rx_cyc = cyc;
    tick();
    rx_done     = 1'b0;
  endtask

  task automatic send_raw(input logic [31:0] bytes, input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      drive_byte(bytes[31-8*i -: 8]);
      if (i < len - 1) repeat (gap) tick();
    end
  endtask

  task automatic send_cmd(input logic [7:0] b0, b1, b2, input int len, input int gap);
    logic [31:0] bytes = {b0, b1, b2, 8'h00};
    int          n = len;
`ifdef UART_RESP_CHECKSUM_EN
    if (b0 == 8'h57 || b0 == 8'h52) begin
      bytes[31-8*len -: 8] = b0 ^ ((len > 1) ? b1 : 8'h00) ^ ((len > 2) ? b2 : 8'h00);
      n = len + 1;
    end
`endif
    send_raw(bytes, n, gap);
  endtask

  task automatic finish_tx();
    tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic expect_resp(input string name, input logic [7:0] exp_resp, input logic exp_err,
                             input int e0, input int t0);
    for (int i = 0; i < 100 && txq.size() == 0; i++) tick();
    check($sformatf("%s tx_en count", name), txq.size(), 1);
    if (txq.size() > 0) check($sformatf("%s response", name), txq[0], exp_resp);
    check($sformatf("%s latency", name), txen_cyc - last_rx_cyc, 2);
    finish_tx();
    check($sformatf("%s busy after tx_done", name), busy, 1'b0);
    check($sformatf("%s err pulses", name), err_cnt - e0, exp_err);
    check($sformatf("%s tx_en pulses", name), txen_cnt - t0, 1);
    check($sformatf("%s regs_out", name), regs_out, model_flat());
  endtask

  task automatic do_frame(input string name, input logic [7:0] b0, b1, b2, input int len,
                          input logic [7:0] exp_resp, input logic exp_err, input int gap);
    int e0 = err_cnt, t0 = txen_cnt;
    txq.delete();
    send_cmd(b0, b1, b2, len, gap);
    expect_resp(name, exp_resp, exp_err, e0, t0);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         len;
    logic [7:0] exp_resp;
    logic       exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [7:0] resp, b0, b1, b2;
    logic       nak;
    int         e0, t0, sel, len;

    vecs[0] = '{8'h57, 8'h03, 8'hA5, 3, 8'h06, 1'b0};
    vecs[1] = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 1'b0};
    vecs[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 1'b1};
    vecs[3] = '{8'h57, 8'h10, 8'hFF, 3, 8'h15, 1'b1};
    vecs[4] = '{8'h57, 8'h0F, 8'h7E, 3, 8'h06, 1'b0};
    vecs[5] = '{8'h52, 8'h0F, 8'h00, 2, 8'h7E, 1'b0};
    vecs[6] = '{8'h52, 8'h10, 8'h00, 2, 8'h15, 1'b1};
    vecs[7] = '{8'h52, 8'hFF, 8'h00, 2, 8'h15, 1'b1};
    vecs[8] = '{8'h57, 8'h00, 8'hC3, 3, 8'h06, 1'b0};
    vecs[9] = '{8'h52, 8'h00, 8'h00, 2, 8'hC3, 1'b0};

    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) tick();
    check("reset regs_out", regs_out, '0);
    check("reset tx_en", tx_en, 1'b0);
    check("reset tx_data", tx_data, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset err", err, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      model_exec(vecs[i].b0, vecs[i].b1, vecs[i].b2, resp, nak);
      do_frame($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].len,
               vecs[i].exp_resp, vecs[i].exp_err, 0);
    end

    // Timeout: frame stalls after ADDR, expiry lands TO cycles after the last byte.
    e0 = err_cnt; t0 = txen_cnt;
    drive_byte(8'h57);
    drive_byte(8'h02);
    repeat (TO - 1) tick();
    check("timeout err on expiry cycle", err, 1'b1);
    check("timeout busy before expiry", busy, 1'b1);
    tick();
    check("timeout busy after abort", busy, 1'b0);
    repeat (5) tick();
    check("timeout err pulses", err_cnt - e0, 1);
    check("timeout no tx_en", txen_cnt - t0, 0);
    do_frame("read after timeout", 8'h52, 8'h02, 8'h00, 2, 8'h00, 1'b0, 0);

    // A byte arriving on the expiry cycle must win over the timeout.
    e0 = err_cnt; t0 = txen_cnt;
    txq.delete();
    drive_byte(8'h57);
    repeat (TO - 1) tick();
    drive_byte(8'h05);
    drive_byte(8'h33);
`ifdef UART_RESP_CHECKSUM_EN
    drive_byte(8'h57 ^ 8'h05 ^ 8'h33);
`endif
    model[5] = 8'h33;
    expect_resp("rx beats timeout", 8'h06, 1'b0, e0, t0);

    // Backpressure, then a byte injected during WAIT_TX.
    e0 = err_cnt; t0 = txen_cnt;
    tx_busy = 1'b1;
    send_cmd(8'h52, 8'h03, 8'h00, 2, 0);
    repeat (50) tick();
    check("bp no early tx_en", txen_cnt - t0, 0);
    check("bp busy held", busy, 1'b1);
    tx_busy = 1'b0;
    #1;
    check("bp tx_en on busy fall", tx_en, 1'b1);
    check("bp tx_data", tx_data, model[3]);
    tick();
    check("bp tx_en single pulse", tx_en, 1'b0);
    drive_byte(8'h41);
    drive_byte(8'h52);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (4) tick();
    check("drop busy after tx_done", busy, 1'b0);
    check("drop no err", err_cnt - e0, 0);
    check("drop no extra tx_en", txen_cnt - t0, 1);

`ifdef UART_RESP_CHECKSUM_EN
    e0 = err_cnt; t0 = txen_cnt;
    txq.delete();
    send_raw({8'h57, 8'h01, 8'h3C, 8'h6A}, 4, 0);
    model[1] = 8'h3C;
    expect_resp("csum good", 8'h06, 1'b0, e0, t0);
    e0 = err_cnt; t0 = txen_cnt;
    txq.delete();
    send_raw({8'h57, 8'h01, 8'h3C, 8'h00}, 4, 0);
    expect_resp("csum bad", 8'h15, 1'b1, e0, t0);
    e0 = err_cnt; t0 = txen_cnt;
    txq.delete();
    send_raw({8'h57, 8'h01, 8'h99, 8'h00}, 4, 0);
    expect_resp("csum bad no write", 8'h15, 1'b1, e0, t0);
`endif

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      b1  = 8'($urandom_range(0, 23));
      b2  = 8'($urandom);
      if (sel < 5)      begin b0 = 8'h57; len = 3; end
      else if (sel < 9) begin b0 = 8'h52; len = 2; end
      else begin
        b0 = 8'($urandom);
        if (b0 == 8'h57 || b0 == 8'h52) b0 = 8'h00;
        len = 1;
      end
      model_exec(b0, b1, b2, resp, nak);
      do_frame($sformatf("rand%0d", i), b0, b1, b2, len, resp, nak, $urandom_range(0, 3));
    end

    // Asynchronous reset while waiting in SEND, released between clock edges.
    tx_busy = 1'b1;
    send_cmd(8'h52, 8'h03, 8'h00, 2, 0);
    tick();
    check("pre-reset busy in SEND", busy, 1'b1);
    #2;
    rst     = 1'b0;
    tx_busy = 1'b0;
    #1;
    check("async reset tx_en", tx_en, 1'b0);
    check("async reset regs_out", regs_out, '0);
    check("async reset busy", busy, 1'b0);
    check("async reset tx_data", tx_data, 8'h00);
    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    tick();
    rst = 1'b1;
    tick();
    do_frame("read after reset", 8'h52, 8'h03, 8'h00, 2, 8'h00, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Register-access command responder that sits on the far side of a UART link, between the `rx_*` and `tx_*` byte interfaces of a `uart_top` instance. It parses a byte-oriented command protocol from received bytes and executes writes and reads against an internal register file. It returns one response byte per command through the transmitter handshake. A remote host uses it to configure and read back a design over a serial line.

## Interface
- `NREGS`, default 16: number of 8-bit registers (1..256).
- `TIMEOUT_CYC`, default 100000: clock cycles of inter-byte silence that abort a partial frame (≥2).
- `clk` in 1: system clock, the same clock as `uart_top`.
- `rst` in 1: asynchronous, active-low reset.
- `rx_done` in 1: one-cycle pulse; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `tx_busy` in 1: transmitter is occupied.
- `tx_done` in 1: one-cycle pulse when a byte has finished transmitting.
- `tx_en` out 1: one-cycle pulse that starts transmission of `tx_data`.
- `tx_data` out 8: response byte; held stable from `tx_en` until `tx_done`.
- `regs_out` out 8*NREGS: flattened register file; register k is at bits [8k+7:8k].
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse on a NAK or a timeout abort.

## Operation
- Frame formats:
  - Write: 0x57, ADDR, DATA. Response is 0x06 (ACK).
  - Read: 0x52, ADDR. Response is the value of register ADDR.
  - Any other first byte: response 0x15 (NAK), issued right after that byte.
  - ADDR ≥ NREGS: NAK; no write occurs.
- States:
  - IDLE: an `rx_done` carrying 0x57 or 0x52 goes to GET_ADDR. Any other byte goes to EXEC with NAK selected.
  - GET_ADDR: `rx_done` latches ADDR. Write goes to GET_DATA; read goes to EXEC (or GET_CSUM).
  - GET_DATA: `rx_done` latches DATA, then goes to EXEC (or GET_CSUM).
  - EXEC: one cycle. Performs the write if it is legal and selects the response byte, then goes to SEND.
  - SEND: waits for `tx_busy`=0, pulses `tx_en` for one cycle, then goes to WAIT_TX.
  - WAIT_TX: `tx_done` returns to IDLE.
- Timeout: an idle counter runs in GET_ADDR, GET_DATA and GET_CSUM, and is cleared by every `rx_done`.
  - When the count reaches TIMEOUT_CYC-1, the block returns to IDLE, pulses `err`, and sends no response.
  - If `rx_done` arrives in the same cycle as the timeout, `rx_done` wins.
- `rx_done` arriving in EXEC, SEND or WAIT_TX is dropped silently; no queueing.
- `err` pulses in the EXEC cycle whenever the response is NAK.

## Timing
- Reset values: all registers 0x00, state IDLE, `tx_en`=0, `tx_data`=0x00, `busy`=0, `err`=0, counter 0.
- Reset is asynchronous. Asserting it mid-frame or mid-transmit aborts immediately, and `tx_en` never glitches high.
- Let cycle N be the `rx_done` of the last frame byte:
  - Cycle N+1: EXEC. The register write is visible on `regs_out` from N+2.
  - Cycle N+2: earliest `tx_en`, if `tx_busy`=0. Otherwise `tx_en` fires in the first cycle after `tx_busy` falls.
- A read response carries the register value as sampled in EXEC, including a write that was just completed.
- The 8-bit ADDR compares against NREGS unsigned. No wrap-around: for example, 0x10 is illegal when NREGS=16.

## Configuration
- `UART_RESP_CHECKSUM_EN` defined:
  - Each command frame gains a trailing byte equal to the XOR of all preceding frame bytes.
  - GET_CSUM sits between the last payload byte and EXEC.
  - A mismatch yields NAK and no write.
  - Invalid first bytes still NAK immediately, without waiting for a checksum.
- `UART_RESP_CHECKSUM_EN` undefined: no GET_CSUM state, and frames are exactly as listed above.

## Test plan
- Write then read (checksum off):
  - Send 0x57,0x03,0xA5: expect `tx_en` with 0x06, and `regs_out`[31:24]=0xA5.
  - Then send 0x52,0x03: expect response 0xA5.
- Bad command: send 0x41. Expect an `err` pulse, response 0x15, and `regs_out` unchanged.
- Out of range: send 0x57,0x10,0xFF with NREGS=16. Expect 0x15 and no register change.
- Timeout: send 0x57,0x02, then no byte for TIMEOUT_CYC cycles.
  - Expect an `err` pulse, `busy`=0, and no `tx_en`.
  - A following 0x52,0x02 returns 0x00.
- Backpressure and drop:
  - Hold `tx_busy`=1 for 50 cycles after a read frame: `tx_en` fires exactly in the first cycle after `tx_busy` falls.
  - An `rx_done` injected during WAIT_TX is ignored.
- Checksum build (macro defined):
  - Send 0x57,0x01,0x3C,0x6A (XOR of 0x57,0x01,0x3C = 0x6A): expect 0x06.
  - Send 0x57,0x01,0x3C,0x00: expect 0x15, and register 1 keeps its prior value.
- Reset: assert `rst` low during SEND. Expect `tx_en`=0 and all `regs_out`=0 immediately, without waiting for a clock edge.
